mem_arbiter: RTL and testbench

Single owner of the 4-cycle pipelined main memory (`memory4c`). It arbitrates three requesters: icache block fill, dcache block fill, and dcache write-through. For a fill it sequences the 8-word burst itself, issuing one read per cycle and counting `data_valid` returns, and it streams each returned word back with its word offset. It replaces the ad-hoc address/enable muxing at the cache-controller level, and it removes any need for cross-coupled busy signals between the two fill FSMs.

---
 rtl/mem_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Single owner of the 4-cycle pipelined main memory. Arbitrates icache fill,
// dcache fill and write-through, and sequences each 8-word fill burst.
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int WORDS  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_req,
    input  logic [ADDR_W-1:0]        i_addr,
    input  logic                     d_req,
    input  logic [ADDR_W-1:0]        d_addr,
    input  logic                     w_req,
    input  logic [ADDR_W-1:0]        w_addr,
    input  logic [DATA_W-1:0]        w_data,
    output logic                     i_gnt,
    output logic                     d_gnt,
    output logic                     w_ack,
    output logic                     i_done,
    output logic                     d_done,
    output logic                     fill_valid,
    output logic [$clog2(WORDS)-1:0] fill_word,
    output logic [DATA_W-1:0]        fill_data,
    output logic                     busy,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_data_in,
    output logic                     mem_enable,
    output logic                     mem_wr,
    input  logic [DATA_W-1:0]        mem_data_out,
    input  logic                     mem_data_valid
);

    localparam int OFF_W    = $clog2(WORDS);
    localparam int BASE_LSB = OFF_W + 1;
    localparam int BASE_W   = ADDR_W - BASE_LSB;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_FILL  = 2'd2;

    localparam logic [OFF_W:0]   ISSUE_ZERO = {(OFF_W + 1){1'b0}};
    localparam logic [OFF_W:0]   ISSUE_INC  = {{OFF_W{1'b0}}, 1'b1};
    localparam logic [OFF_W-1:0] RET_ZERO   = {OFF_W{1'b0}};
    localparam logic [OFF_W-1:0] RET_INC    = {{(OFF_W - 1){1'b0}}, 1'b1};
    localparam logic [OFF_W-1:0] RET_LAST   = {OFF_W{1'b1}};

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic              owner_r;
    logic              owner_nxt_s;
    logic [BASE_W-1:0] base_r;
    logic [BASE_W-1:0] base_nxt_s;
    logic [OFF_W:0]    issue_cnt_r;
    logic [OFF_W:0]    issue_cnt_nxt_s;
    logic [OFF_W-1:0]  ret_cnt_r;
    logic [OFF_W-1:0]  ret_cnt_nxt_s;
    logic              last_gnt_r;
    logic              last_gnt_nxt_s;

    logic              pick_d_s;
    logic              issue_done_s;
    logic              fill_last_s;
    logic              unused_s;

    // The byte/word offset bits of a miss address never reach the memory.
    assign unused_s = ^{i_addr[OFF_W:0], d_addr[OFF_W:0]};

    // On a fill tie the requester that was not served last wins.
    assign pick_d_s     = d_req & (~i_req | ~last_gnt_r);
    assign issue_done_s = issue_cnt_r[OFF_W];
    assign fill_last_s  = mem_data_valid & (ret_cnt_r == RET_LAST);

    // Next-state, arbitration and burst counters
    always_comb begin
        state_nxt_s     = state_r;
        owner_nxt_s     = owner_r;
        base_nxt_s      = base_r;
        issue_cnt_nxt_s = issue_cnt_r;
        ret_cnt_nxt_s   = ret_cnt_r;
        last_gnt_nxt_s  = last_gnt_r;
        case (state_r)
            ST_IDLE: begin
                if (w_req) begin
                    state_nxt_s = ST_WRITE;
                end else if (i_req || d_req) begin
                    state_nxt_s     = ST_FILL;
                    owner_nxt_s     = pick_d_s;
                    base_nxt_s      = pick_d_s ? d_addr[ADDR_W-1:BASE_LSB]
                                               : i_addr[ADDR_W-1:BASE_LSB];
                    issue_cnt_nxt_s = ISSUE_ZERO;
                    ret_cnt_nxt_s   = RET_ZERO;
                    last_gnt_nxt_s  = pick_d_s;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                state_nxt_s = ST_IDLE;
            end
            ST_FILL: begin
                if (!issue_done_s) begin
                    issue_cnt_nxt_s = issue_cnt_r + ISSUE_INC;
                end else begin
                    issue_cnt_nxt_s = issue_cnt_r;
                end
                if (mem_data_valid) begin
                    ret_cnt_nxt_s = ret_cnt_r + RET_INC;
                end else begin
                    ret_cnt_nxt_s = ret_cnt_r;
                end
                if (fill_last_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_FILL;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and burst registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            owner_r     <= 1'b0;
            base_r      <= {BASE_W{1'b0}};
            issue_cnt_r <= ISSUE_ZERO;
            ret_cnt_r   <= RET_ZERO;
            last_gnt_r  <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            owner_r     <= owner_nxt_s;
            base_r      <= base_nxt_s;
            issue_cnt_r <= issue_cnt_nxt_s;
            ret_cnt_r   <= ret_cnt_nxt_s;
            last_gnt_r  <= last_gnt_nxt_s;
        end
    end

    // Output decode; returns outside FILL (including stray ones after reset) are dropped.
    always_comb begin
        i_gnt       = 1'b0;
        d_gnt       = 1'b0;
        w_ack       = 1'b0;
        i_done      = 1'b0;
        d_done      = 1'b0;
        fill_valid  = 1'b0;
        fill_word   = RET_ZERO;
        fill_data   = {DATA_W{1'b0}};
        busy        = 1'b0;
        mem_addr    = {ADDR_W{1'b0}};
        mem_data_in = {DATA_W{1'b0}};
        mem_enable  = 1'b0;
        mem_wr      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                busy = 1'b0;
            end
            ST_WRITE: begin
                busy        = 1'b1;
                mem_enable  = 1'b1;
                mem_wr      = 1'b1;
                mem_addr    = w_addr;
                mem_data_in = w_data;
                w_ack       = 1'b1;
            end
            ST_FILL: begin
                busy      = 1'b1;
                i_gnt     = ~owner_r;
                d_gnt     = owner_r;
                fill_word = ret_cnt_r;
                if (!issue_done_s) begin
                    mem_enable = 1'b1;
                    mem_addr   = {base_r, issue_cnt_r[OFF_W-1:0], 1'b0};
                end else begin
                    mem_enable = 1'b0;
                end
                if (mem_data_valid) begin
                    fill_valid = 1'b1;
                    fill_data  = mem_data_out;
                end else begin
                    fill_valid = 1'b0;
                end
                if (fill_last_s) begin
                    i_done = ~owner_r;
                    d_done = owner_r;
                end else begin
                    i_done = 1'b0;
                end
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a 4-cycle memory model, a request-level
// reference model feeding expectation queues, and a decoupled monitor.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, d_req, w_req;
    logic [15:0] i_addr, d_addr, w_addr, w_data;
    logic        i_gnt, d_gnt, w_ack, i_done, d_done, fill_valid, busy;
    logic [2:0]  fill_word;
    logic [15:0] fill_data, mem_addr, mem_data_in, mem_data_out;
    logic        mem_enable, mem_wr, mem_data_valid;
    logic        force_valid;

    int checks = 0;
    int errors = 0;
    int fv_count = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .d_req(d_req), .d_addr(d_addr),
        .w_req(w_req), .w_addr(w_addr), .w_data(w_data),
        .i_gnt(i_gnt), .d_gnt(d_gnt), .w_ack(w_ack), .i_done(i_done), .d_done(d_done),
        .fill_valid(fill_valid), .fill_word(fill_word), .fill_data(fill_data),
        .busy(busy), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_enable(mem_enable), .mem_wr(mem_wr),
        .mem_data_out(mem_data_out), .mem_data_valid(mem_data_valid)
    );

    function automatic logic [15:0] init_val(input logic [15:0] byte_addr);
        return byte_addr * 16'd7 + 16'h1357;
    endfunction

    // Memory model: word-addressed storage, reads return 4 cycles after issue.
    logic [15:0] mem_arr [0:32767];
    bit          written [0:32767];
    logic [3:0]  pv = 4'b0;
    logic [15:0] pd0 = 16'h0, pd1 = 16'h0, pd2 = 16'h0, pd3 = 16'h0;

    always @(posedge clk) begin
        if (mem_enable && mem_wr) begin
            mem_arr[mem_addr[15:1]] <= mem_data_in;
            written[mem_addr[15:1]] <= 1'b1;
        end
        pv  <= {pv[2:0], mem_enable & ~mem_wr};
        pd0 <= written[mem_addr[15:1]] ? mem_arr[mem_addr[15:1]] : init_val({mem_addr[15:1], 1'b0});
        pd1 <= pd0;
        pd2 <= pd1;
        pd3 <= pd2;
    end
    assign mem_data_valid = pv[3] | force_valid;
    assign mem_data_out   = pd3;

    // Reference model: expectation queues and last-served fill owner.
    typedef struct { logic [15:0] addr; logic wr; logic [15:0] data; } iss_t;
    typedef struct { logic owner; logic [2:0] word; logic [15:0] data; logic last; } fil_t;
    iss_t exp_iss[$];
    fil_t exp_fil[$];
    logic [15:0] ref_w [int];
    logic        m_last = 1'b0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        int k = int'(a[15:1]);
        if (ref_w.exists(k)) return ref_w[k];
        return init_val({a[15:1], 1'b0});
    endfunction

    task automatic push_fill(input logic owner, input logic [15:0] a);
        logic [15:0] base = {a[15:4], 4'h0};
        for (int k = 0; k < 8; k++) begin
            logic [15:0] wa = base + 16'(2 * k);
            exp_iss.push_back('{wa, 1'b0, 16'h0});
            exp_fil.push_back('{owner, 3'(k), ref_rd(wa), (k == 7)});
        end
        m_last = owner;
    endtask

    task automatic predict(input bit ion, input logic [15:0] ia, input bit don, input logic [15:0] da,
                           input bit won, input logic [15:0] wa, input logic [15:0] wd);
        if (won) begin
            exp_iss.push_back('{wa, 1'b1, wd});
            ref_w[int'(wa[15:1])] = wd;
        end
        if (ion && don) begin
            if (m_last == 1'b0) begin
                push_fill(1'b1, da);
                push_fill(1'b0, ia);
            end else begin
                push_fill(1'b0, ia);
                push_fill(1'b1, da);
            end
        end else if (ion) begin
            push_fill(1'b0, ia);
        end else if (don) begin
            push_fill(1'b1, da);
        end
    endtask

    task automatic drive(input bit ion, input logic [15:0] ia, input bit don, input logic [15:0] da,
                         input bit won, input logic [15:0] wa, input logic [15:0] wd);
        i_req = ion; i_addr = ia; d_req = don; d_addr = da;
        w_req = won; w_addr = wa; w_data = wd;
    endtask

    // Requesters hold until their ack/done, then drop after that edge.
    task automatic serve(input int budget);
        int  n = 0;
        bit  wa, id, dd;
        while ((i_req || d_req || w_req || busy) && n < budget) begin
            @(negedge clk);
            wa = w_ack; id = i_done; dd = d_done;
            @(posedge clk); #1;
            if (wa) w_req = 1'b0;
            if (id) i_req = 1'b0;
            if (dd) d_req = 1'b0;
            n++;
        end
        chk(n < budget, "serve_timeout", 64'(n), 64'(budget));
        chk(exp_iss.size() == 0, "issue_queue_drained", 64'(exp_iss.size()), 64'd0);
        chk(exp_fil.size() == 0, "fill_queue_drained", 64'(exp_fil.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            i_req = 1'($urandom); d_req = 1'($urandom); w_req = 1'($urandom);
            i_addr = 16'($urandom); d_addr = 16'($urandom);
            w_addr = 16'($urandom); w_data = 16'($urandom);
            force_valid = 1'($urandom);
            @(negedge clk);
            chk({i_gnt, d_gnt, w_ack, i_done, d_done, fill_valid, fill_word, busy, mem_enable, mem_wr} == 12'h0
                && fill_data == 16'h0 && mem_addr == 16'h0 && mem_data_in == 16'h0,
                "reset_outputs", {i_gnt, d_gnt, w_ack, i_done, d_done, fill_valid, busy, mem_enable, mem_wr,
                fill_word, fill_data, mem_addr}, 64'h0);
            @(posedge clk); #1;
        end
        drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
        force_valid = 1'b0;
        m_last = 1'b0;
        exp_iss.delete();
        exp_fil.delete();
        rst_n = 1'b1;
    endtask

    // Monitor: pops expectations whenever the DUT presents an issue or a fill word.
    initial begin
        iss_t e;
        fil_t f;
        int   gnt_len = 0;
        bit   prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (mem_enable) begin
                    chk(exp_iss.size() != 0, "issue_expected", {mem_wr, mem_addr}, 64'h0);
                    if (exp_iss.size() != 0) begin
                        e = exp_iss.pop_front();
                        chk(mem_addr == e.addr && mem_wr == e.wr, "issue_addr_wr", {mem_wr, mem_addr}, {e.wr, e.addr});
                        chk(w_ack == e.wr, "w_ack", 64'(w_ack), 64'(e.wr));
                        if (e.wr) chk(mem_data_in == e.data, "write_data", 64'(mem_data_in), 64'(e.data));
                    end
                end
                if (fill_valid) begin
                    fv_count++;
                    chk(exp_fil.size() != 0, "fill_expected", {fill_word, fill_data}, 64'h0);
                    if (exp_fil.size() != 0) begin
                        f = exp_fil.pop_front();
                        chk(fill_word == f.word && fill_data == f.data, "fill_word_data",
                            {fill_word, fill_data}, {f.word, f.data});
                        chk(i_gnt == ~f.owner && d_gnt == f.owner, "fill_owner", {i_gnt, d_gnt}, {~f.owner, f.owner});
                        chk(i_done == (f.last & ~f.owner) && d_done == (f.last & f.owner), "done_pulse",
                            {i_done, d_done}, {f.last & ~f.owner, f.last & f.owner});
                    end
                end else if (i_done || d_done) begin
                    chk(1'b0 == (i_done | d_done), "done_without_fill", {i_done, d_done}, 64'h0);
                end
                if (prev_done) chk(!i_gnt && !d_gnt, "gnt_after_done", {i_gnt, d_gnt}, 64'h0);
                if (i_gnt || d_gnt) gnt_len++;
                else gnt_len = 0;
                if (i_done || d_done) begin
                    chk(gnt_len == 12, "fill_length", 64'(gnt_len), 64'd12);
                    gnt_len = 0;
                end
                prev_done = i_done | d_done;
            end else begin
                gnt_len = 0;
                prev_done = 1'b0;
            end
        end
    end

    initial begin
        int snap;
        bit ion, don, won;
        logic [15:0] ia, da, wa, wd;
        rst_n = 1'b0;
        force_valid = 1'b0;
        drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
        @(posedge clk); #1;

        // 1: reset outputs, then idle with no requests
        do_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk(!mem_enable && !busy, "idle_quiet", {mem_enable, busy}, 64'h0);
        end
        @(posedge clk); #1;

        // 2: single icache fill, grant one cycle after request
        predict(1'b1, 16'h1236, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
        drive(1'b1, 16'h1236, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
        @(negedge clk);
        chk(!i_gnt, "gnt_not_same_cycle", 64'(i_gnt), 64'd0);
        @(negedge clk);
        chk(i_gnt, "gnt_next_cycle", 64'(i_gnt), 64'd1);
        serve(40);

        // 3: simultaneous fills after reset alternate starting with dcache
        do_reset();
        @(posedge clk); #1;
        predict(1'b1, 16'h8000, 1'b1, 16'h0040, 1'b0, 16'h0, 16'h0);
        drive(1'b1, 16'h8000, 1'b1, 16'h0040, 1'b0, 16'h0, 16'h0);
        serve(60);
        predict(1'b1, 16'h8000, 1'b1, 16'h0040, 1'b0, 16'h0, 16'h0);
        drive(1'b1, 16'h8000, 1'b1, 16'h0040, 1'b0, 16'h0, 16'h0);
        serve(60);

        // 4: write-through beats a fill, and the fill sees the written word
        predict(1'b0, 16'h0, 1'b1, 16'h0100, 1'b1, 16'h0100, 16'hBEEF);
        drive(1'b0, 16'h0, 1'b1, 16'h0100, 1'b1, 16'h0100, 16'hBEEF);
        serve(40);

        // 5: reset after three fill words; stray returns must not surface
        predict(1'b1, 16'h2468, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
        drive(1'b1, 16'h2468, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
        snap = fv_count;
        for (int c = 0; c < 30 && fv_count < snap + 3; c++) begin
            @(posedge clk); #1;
        end
        chk(fv_count == snap + 3, "three_words_before_reset", 64'(fv_count - snap), 64'd3);
        rst_n = 1'b0;
        i_req = 1'b0;
        exp_iss.delete();
        exp_fil.delete();
        m_last = 1'b0;
        @(negedge clk);
        chk(!i_gnt && !d_gnt && !busy, "reset_mid_fill", {i_gnt, d_gnt, busy}, 64'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        snap = fv_count;
        for (int c = 0; c < 8; c++) @(posedge clk);
        #1;
        chk(fv_count == snap, "no_stray_fill", 64'(fv_count - snap), 64'd0);

        // 6: forced valid while idle is ignored; next fill starts at word 0
        force_valid = 1'b1;
        snap = fv_count;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk(!fill_valid && !busy, "idle_valid_ignored", {fill_valid, busy}, 64'h0);
        end
        @(posedge clk); #1;
        force_valid = 1'b0;
        chk(fv_count == snap, "idle_fill_count", 64'(fv_count - snap), 64'd0);
        predict(1'b0, 16'h0, 1'b1, 16'h3A5C, 1'b0, 16'h0, 16'h0);
        drive(1'b0, 16'h0, 1'b1, 16'h3A5C, 1'b0, 16'h0, 16'h0);
        serve(40);

        // 7: randomized request mixes over a small address window
        for (int t = 0; t < 25; t++) begin
            ion = 1'($urandom); don = 1'($urandom); won = 1'($urandom);
            if (!ion && !don && !won) ion = 1'b1;
            ia = 16'(($urandom % 4) * 16 + ($urandom % 16)) | 16'h4000;
            da = 16'(($urandom % 4) * 16 + ($urandom % 16)) | 16'h4000;
            wa = (16'(($urandom % 4) * 16 + ($urandom % 16)) | 16'h4000) & 16'hFFFE;
            wd = 16'($urandom);
            predict(ion, ia, don, da, won, wa, wd);
            drive(ion, ia, don, da, won, wa, wd);
            serve(80);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
